// File: rtl/varredura_matriz.sv
// rtl/varredura_matriz.sv - 8x8 LED matrix row scanner with per-frame input snapshot
// Optional end-of-game blink enabled by defining PISCA_FIM_EN.
module varredura_matriz #(
  parameter int DIV_LINHA     = 1000,
  parameter int BLANK_CICLOS  = 16,
  parameter int LARG_RAQUETE  = 2,
  parameter int PISCA_QUADROS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] linha_bola,
  input  logic [2:0] coluna_bola,
  input  logic [2:0] raquete_cima,
  input  logic [2:0] raquete_baixo,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic [7:0] linhas,
  output logic [7:0] colunas,
  output logic       fim_quadro
);

  localparam int             CW        = $clog2(DIV_LINHA);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(DIV_LINHA - 1);
  localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CICLOS);

  typedef enum logic {ST_BLANK, ST_SHOW} estado_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    linha_q, linha_d;
  logic [2:0]    lin_s_q, col_s_q, cima_s_q, baixo_s_q;
  estado_t       estado_q, estado_d;
  logic [7:0]    linhas_q, linhas_d;
  logic [7:0]    colunas_q, colunas_d;
  logic          fim_q, fim_d;
  logic          fim_linha, snap, aceso;
  logic [7:0]    padrao;

  function automatic logic [7:0] mascara_raquete(input logic [2:0] p);
    logic [7:0] m;
    m = 8'h00;
    for (int c = 0; c < 8; c++) begin
      m[c] = (c >= int'(p)) && (c < int'(p) + LARG_RAQUETE);
    end
    return m;
  endfunction

  always_comb begin
    fim_linha = (cnt_q == CNT_MAX);
    snap      = fim_linha && (linha_q == 3'd7);
    cnt_d     = fim_linha ? '0 : cnt_q + 1'b1;
    linha_d   = fim_linha ? linha_q + 3'd1 : linha_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      linha_q   <= 3'd0;
      lin_s_q   <= 3'd0;
      col_s_q   <= 3'd0;
      cima_s_q  <= 3'd0;
      baixo_s_q <= 3'd0;
    end else begin
      cnt_q   <= cnt_d;
      linha_q <= linha_d;
      if (snap) begin
        lin_s_q   <= linha_bola;
        col_s_q   <= coluna_bola;
        cima_s_q  <= raquete_cima;
        baixo_s_q <= raquete_baixo;
      end
    end
  end

`ifdef PISCA_FIM_EN
  localparam int            QW   = $clog2(PISCA_QUADROS + 1);
  localparam logic [QW-1:0] QMAX = QW'(PISCA_QUADROS - 1);

  logic          fim_s_q;
  logic          fase_q, fase_d;
  logic [QW-1:0] qcnt_q, qcnt_d;

  // Advance on frames that were shown in end state; a clean snapshot restarts lit.
  always_comb begin
    fase_d = fase_q;
    qcnt_d = qcnt_q;
    if (snap) begin
      if (!(ganhou | perdeu)) begin
        fase_d = 1'b0;
        qcnt_d = '0;
      end else if (fim_s_q) begin
        if (qcnt_q == QMAX) begin
          qcnt_d = '0;
          fase_d = ~fase_q;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fim_s_q <= 1'b0;
      fase_q  <= 1'b0;
      qcnt_q  <= '0;
    end else begin
      fase_q <= fase_d;
      qcnt_q <= qcnt_d;
      if (snap) fim_s_q <= ganhou | perdeu;
    end
  end

  assign aceso = ~fase_q;
`else
  logic unused_fim_jogo;
  assign unused_fim_jogo = ganhou ^ perdeu;
  assign aceso           = 1'b1;
`endif

  always_comb begin
    padrao = 8'h00;
    if (linha_q == lin_s_q) padrao[col_s_q] = 1'b1;
    if (linha_q == 3'd0) padrao = padrao | mascara_raquete(cima_s_q);
    if (linha_q == 3'd7) padrao = padrao | mascara_raquete(baixo_s_q);
  end

  // State tracks cnt_q, so it is registered from the next counter value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado_q <= ST_BLANK;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    linhas_d  = 8'h00;
    colunas_d = 8'hFF;
    fim_d     = snap;
    if (estado_q == ST_SHOW && aceso) begin
      linhas_d  = 8'b1 << linha_q;
      colunas_d = ~padrao;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      linhas_q  <= 8'h00;
      colunas_q <= 8'hFF;
      fim_q     <= 1'b0;
    end else begin
      linhas_q  <= linhas_d;
      colunas_q <= colunas_d;
      fim_q     <= fim_d;
    end
  end

  assign linhas     = linhas_q;
  assign colunas    = colunas_q;
  assign fim_quadro = fim_q;

endmodule

// File: tb/tb_varredura_matriz.sv
// tb/tb_varredura_matriz.sv - directed bench for varredura_matriz (DIV=20, BLANK=4, LARG=2, PISCA=2)
module tb_varredura_matriz;

  logic       clk;
  logic       reset;
  logic [2:0] linha_bola, coluna_bola, raquete_cima, raquete_baixo;
  logic       ganhou, perdeu;
  logic [7:0] linhas, colunas;
  logic       fim_quadro;

  int vecs;
  int errs;
  logic [7:0] lin_cap [8];
  logic [7:0] col_cap [8];

  varredura_matriz #(
    .DIV_LINHA(20), .BLANK_CICLOS(4), .LARG_RAQUETE(2), .PISCA_QUADROS(2)
  ) dut (
    .clk(clk), .reset(reset),
    .linha_bola(linha_bola), .coluna_bola(coluna_bola),
    .raquete_cima(raquete_cima), .raquete_baixo(raquete_baixo),
    .ganhou(ganhou), .perdeu(perdeu),
    .linhas(linhas), .colunas(colunas), .fim_quadro(fim_quadro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at the negedge right after the fim_quadro edge.
  task automatic wait_fim();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (fim_quadro === 1'b1) seen = 1'b1;
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("FAIL wait_fim: fim_quadro not seen within 400 cycles");
    end
  endtask

  // Captures the middle of each row's SHOW window; optionally changes inputs during row 2.
  task automatic capture_frame(input bit do_chg, input logic [2:0] nl, input logic [2:0] nc,
                               input logic ng);
    wait_fim();
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k % 20 == 10) begin
        lin_cap[(k - 10) / 20] = linhas;
        col_cap[(k - 10) / 20] = colunas;
      end
      if (do_chg && k == 40) begin
        linha_bola  = nl;
        coluna_bola = nc;
        ganhou      = ng;
      end
    end
  endtask

  task automatic check_frame(input string nome, input logic [7:0] exp_col [8]);
    for (int r = 0; r < 8; r++) begin
      vecs++;
      if (lin_cap[r] !== (8'h01 << r) || col_cap[r] !== exp_col[r]) begin
        errs++;
        $display("FAIL %s row %0d: linhas=%h colunas=%h, expected linhas=%h colunas=%h",
                 nome, r, lin_cap[r], col_cap[r], 8'h01 << r, exp_col[r]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (linhas !== 8'h00 || colunas !== 8'hFF || fim_quadro !== 1'b0) begin
      errs++;
      $display("FAIL reset_values: linhas=%h colunas=%h fim=%b, expected 00 FF 0",
               linhas, colunas, fim_quadro);
    end
    reset = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (linhas !== 8'h00 || colunas !== 8'hFF) begin
      errs++;
      $display("FAIL first_blank: linhas=%h colunas=%h, expected 00 FF", linhas, colunas);
    end
    @(posedge clk);
    @(negedge clk);
    vecs++;
    if (linhas !== 8'h01 || colunas !== 8'hFC || fim_quadro !== 1'b0) begin
      errs++;
      $display("FAIL first_show: linhas=%h colunas=%h fim=%b, expected 01 FC 0",
               linhas, colunas, fim_quadro);
    end
  endtask

  task automatic test_frame();
    logic [7:0] e [8];
    linha_bola = 3'd3; coluna_bola = 3'd5; raquete_cima = 3'd2; raquete_baixo = 3'd7;
    capture_frame(1'b0, 3'd0, 3'd0, 1'b0);
    e = '{8'hF3, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    check_frame("frame_ball35", e);
  endtask

  task automatic test_freeze();
    logic [7:0] e [8];
    capture_frame(1'b1, 3'd4, 3'd1, 1'b0);
    e = '{8'hF3, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    check_frame("frozen_midframe", e);
    capture_frame(1'b0, 3'd0, 3'd0, 1'b0);
    e = '{8'hF3, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFF, 8'hFF, 8'h7F};
    check_frame("frame_ball41", e);
  endtask

  task automatic test_timing();
    int bad_scan, bad_fim;
    logic [7:0] exp_l;
    bad_scan = 0;
    bad_fim  = 0;
    wait_fim();
    for (int k = 1; k <= 160; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_l = (((k - 1) % 20) < 4) ? 8'h00 : (8'h01 << ((k - 1) / 20));
      if (linhas !== exp_l) bad_scan++;
      if (fim_quadro !== (k == 160)) bad_fim++;
    end
    vecs++;
    if (bad_scan != 0) begin
      errs++;
      $display("FAIL scan_onehot_blank: %0d bad cycles, expected 0", bad_scan);
    end
    vecs++;
    if (bad_fim != 0) begin
      errs++;
      $display("FAIL fim_spacing: %0d cycles off the 160-cycle pulse pattern, expected 0", bad_fim);
    end
  endtask

  task automatic test_blink();
    logic exp_lit [5];
`ifdef PISCA_FIM_EN
    exp_lit = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp_lit = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    ganhou = 1'b1;
    for (int f = 0; f < 5; f++) begin
      if (f == 3) capture_frame(1'b1, 3'd4, 3'd1, 1'b0);
      else        capture_frame(1'b0, 3'd0, 3'd0, 1'b0);
      vecs++;
      if (exp_lit[f] ? (lin_cap[0] !== 8'h01 || col_cap[0] !== 8'hF3)
                     : (lin_cap[0] !== 8'h00 || col_cap[0] !== 8'hFF)) begin
        errs++;
        $display("FAIL blink_frame%0d: linhas=%h colunas=%h, expected lit=%b",
                 f, lin_cap[0], col_cap[0], exp_lit[f]);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_fim();
    repeat (110) begin
      @(posedge clk);
      @(negedge clk);
    end
    vecs++;
    if (linhas !== 8'h20) begin
      errs++;
      $display("FAIL row5_show: linhas=%h, expected 20", linhas);
    end
    reset = 1'b0;
    #1;
    vecs++;
    if (linhas !== 8'h00 || colunas !== 8'hFF || fim_quadro !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: linhas=%h colunas=%h fim=%b, expected 00 FF 0",
               linhas, colunas, fim_quadro);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (linhas !== 8'h01 || colunas !== 8'hFC) begin
      errs++;
      $display("FAIL restart_row0: linhas=%h colunas=%h, expected 01 FC", linhas, colunas);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b0;
    linha_bola = 3'd0; coluna_bola = 3'd0; raquete_cima = 3'd0; raquete_baixo = 3'd0;
    ganhou = 1'b0; perdeu = 1'b0;
    test_reset();
    test_frame();
    test_freeze();
    test_timing();
    test_blink();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
